rvc_fetch_aligner: RTL
======================

RVC_FETCH_ALIGNER -- requirements
Module: rvc_fetch_aligner

Interface
REQ-001 SHALL have parameter PROGADDR_RESET, default 32'h0000_0000, the first instruction address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port redirect_valid  input  1  load a new fetch PC (branch/jump/trap).
REQ-005 SHALL have port redirect_pc  input  32  new PC; bit 0 ignored.
REQ-006 SHALL have port mem_valid  output  1  memory word read request.
REQ-007 SHALL have port mem_addr  output  32  word address; bits [1:0] always 2'b00.
REQ-008 SHALL have port mem_ready  input  1  read completes this cycle; mem_rdata valid.
REQ-009 SHALL have port mem_rdata  input  32  read data, little-endian halfwords.
REQ-010 SHALL have port out_valid  output  1  instruction available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts instruction.
REQ-012 SHALL have port out_insn  output  32  instruction; 16-bit instructions zero-extended.
REQ-013 SHALL have port out_pc  output  32  address of out_insn.
REQ-014 SHALL have port out_rvc  output  1  1 = 16-bit compressed instruction.

Function
REQ-015 SHALL hold internal pc (bit 0 always 0), a 16-bit halfword buffer buf, buf_valid and buf_addr.
REQ-016 SHALL classify a halfword as 16-bit iff bits [1:0] != 2'b11.
REQ-017 SHALL use states S_FETCH (mem_valid=1), S_OUT (out_valid=1), S_DROP (mem_valid=1, data discarded).
REQ-018 SHALL hold mem_valid and mem_addr stable from assertion until the cycle mem_ready=1.
REQ-019 pc[1]=0, word W fetched at pc: if W[15:0] is 16-bit, SHALL output W[15:0] and load buf=W[31:16], buf_addr=pc+2; else SHALL output W.
REQ-020 pc[1]=1, buf_valid and buf_addr==pc, buf 16-bit: SHALL output buf with no memory fetch.
REQ-021 pc[1]=1, buf_valid and buf_addr==pc, buf 32-bit: SHALL fetch word W at pc+2, output {W[15:0],buf}, load buf=W[31:16], buf_addr=pc+4.
REQ-022 pc[1]=1 without matching buf: SHALL fetch word at pc&~3, load buf from its upper half, then proceed per REQ-020/021 (up to two fetches per instruction).
REQ-023 SHALL enter S_OUT the cycle after the mem_ready completing the instruction, or the cycle after an out handshake when REQ-020 applies to the next pc.
REQ-024 SHALL hold out_insn, out_pc, out_rvc stable while out_valid=1 and out_ready=0.
REQ-025 On out_valid&&out_ready SHALL advance pc by 2 (out_rvc=1) or 4, then go to S_OUT (REQ-020) or S_FETCH.
REQ-026 redirect_valid SHALL have priority over all other events: pc<=redirect_pc&~1, buf_valid<=0, out_valid<=0 next cycle.
REQ-027 redirect in S_FETCH with mem_ready=0 SHALL go to S_DROP keeping mem_valid/mem_addr; the returned word is discarded and a fetch of the new pc starts the following cycle.
REQ-028 redirect coincident with mem_ready SHALL discard that word and fetch the new pc next cycle.
REQ-029 redirect coincident with an out handshake SHALL count the instruction as consumed, then apply REQ-026.
REQ-030 A redirect during S_DROP SHALL replace the pending target; last redirect wins.
REQ-031 pc arithmetic SHALL wrap modulo 2^32 (0xFFFF_FFFE+2 = 0).

Reset
REQ-032 While resetn=0: mem_valid=0, mem_addr=0, out_valid=0, out_insn=0, out_pc=0, out_rvc=0, buf_valid=0, pc=PROGADDR_RESET, state S_FETCH.
REQ-033 First rising edge with resetn=1 SHALL assert mem_valid with mem_addr=PROGADDR_RESET&~3.
REQ-034 Reset asserted mid-fetch SHALL abandon it immediately; no stale data is output after release.

Verification
REQ-035 Reset, word 0x4501_4501 at 0 -> two outputs: (0x0000_4501,pc 0,rvc 1),(0x0000_4501,pc 2,rvc 1); one fetch only.
REQ-036 Word 0x0000_0513 at 0 -> out_insn 0x0000_0513, pc 0, rvc 0; next mem_addr 4.
REQ-037 Words 0x0513_4501 at 0, 0x1234_0000 at 4 -> (0x4501,pc 0),(0x0000_0513,pc 2,rvc 0); then pc 6 with buf 0x1234.
REQ-038 redirect_pc=0x102 while fetch of 0x8 stalled (mem_ready low 3 cycles) -> mem_addr 0x8 held, data dropped, next fetch 0x100, upper half used.
REQ-039 out_ready held 0 for 5 cycles -> outputs stable; redirect during stall -> out_valid 0 next cycle, no pc advance from the stalled instruction.
REQ-040 resetn pulsed low mid-S_OUT -> all outputs 0 asynchronously; restart fetch at PROGADDR_RESET.

Source files
------------

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: turns a stream of aligned 32-bit memory words into
// individual RV32C instructions. Compressed (16-bit) instructions come out
// zero-extended. A 32-bit instruction may straddle two words. The upper
// halfword of the last word is kept in a one-entry buffer so that a
// following compressed instruction needs no extra memory read.
module rvc_fetch_aligner #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        out_rvc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_OUT   = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [15:0] buf_r, buf_s;
  logic        buf_valid_r, buf_valid_s;
  logic [31:0] buf_addr_r, buf_addr_s;
  logic        mem_valid_r, mem_valid_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic        out_valid_r, out_valid_s;
  logic [31:0] out_insn_r, out_insn_s;
  logic [31:0] out_pc_r, out_pc_s;
  logic        out_rvc_r, out_rvc_s;

  logic        hit_s;
  logic [31:0] pc_adv_s;
  logic        hit_adv_s;

  // A halfword is a compressed instruction unless its low two bits are 11.
  function automatic logic is_rvc(input logic [15:0] half);
    return (half[1:0] != 2'b11);
  endfunction

  // Word address to read for an instruction at pc: when the buffer already
  // holds the low half of an odd-halfword instruction, read the next word,
  // otherwise read the word containing pc.
  function automatic logic [31:0] fetch_addr(input logic [31:0] pc,
                                             input logic        bv,
                                             input logic [31:0] baddr);
    logic [31:0] addr;
    if (pc[1] && bv && (baddr == pc)) begin
      addr = (pc + 32'd2) & 32'hFFFF_FFFC;
    end else begin
      addr = pc & 32'hFFFF_FFFC;
    end
    return addr;
  endfunction

  assign hit_s     = pc_r[1] && buf_valid_r && (buf_addr_r == pc_r);
  assign pc_adv_s  = pc_r + (out_rvc_r ? 32'd2 : 32'd4);
  assign hit_adv_s = pc_adv_s[1] && buf_valid_r && (buf_addr_r == pc_adv_s);

  // Next-state and next-output logic; redirect overrides every other event.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    buf_s       = buf_r;
    buf_valid_s = buf_valid_r;
    buf_addr_s  = buf_addr_r;
    mem_valid_s = mem_valid_r;
    mem_addr_s  = mem_addr_r;
    out_valid_s = out_valid_r;
    out_insn_s  = out_insn_r;
    out_pc_s    = out_pc_r;
    out_rvc_s   = out_rvc_r;

    if (redirect_valid) begin
      pc_s        = redirect_pc & 32'hFFFF_FFFE;
      buf_valid_s = 1'b0;
      out_valid_s = 1'b0;
      if ((state_r != S_OUT) && mem_valid_r && !mem_ready) begin
        // An outstanding read must finish first; its data will be dropped.
        state_s = S_DROP;
      end else begin
        state_s     = S_FETCH;
        mem_valid_s = 1'b1;
        mem_addr_s  = redirect_pc & 32'hFFFF_FFFC;
      end
    end else begin
      case (state_r)
        S_FETCH: begin
          if (!mem_valid_r) begin
            // Issue the first read after reset.
            mem_valid_s = 1'b1;
            mem_addr_s  = fetch_addr(pc_r, buf_valid_r, buf_addr_r);
          end else if (mem_ready) begin
            if (!pc_r[1]) begin
              state_s     = S_OUT;
              mem_valid_s = 1'b0;
              out_valid_s = 1'b1;
              out_pc_s    = pc_r;
              if (is_rvc(mem_rdata[15:0])) begin
                out_insn_s  = {16'h0000, mem_rdata[15:0]};
                out_rvc_s   = 1'b1;
                buf_s       = mem_rdata[31:16];
                buf_valid_s = 1'b1;
                buf_addr_s  = pc_r + 32'd2;
              end else begin
                out_insn_s  = mem_rdata;
                out_rvc_s   = 1'b0;
                buf_valid_s = 1'b0;
              end
            end else if (hit_s) begin
              // Second half of a straddling 32-bit instruction.
              state_s     = S_OUT;
              mem_valid_s = 1'b0;
              out_valid_s = 1'b1;
              out_pc_s    = pc_r;
              out_insn_s  = {mem_rdata[15:0], buf_r};
              out_rvc_s   = 1'b0;
              buf_s       = mem_rdata[31:16];
              buf_valid_s = 1'b1;
              buf_addr_s  = pc_r + 32'd4;
            end else begin
              // Odd pc without a buffered halfword: keep the upper half.
              buf_s       = mem_rdata[31:16];
              buf_valid_s = 1'b1;
              buf_addr_s  = pc_r;
              if (is_rvc(mem_rdata[31:16])) begin
                state_s     = S_OUT;
                mem_valid_s = 1'b0;
                out_valid_s = 1'b1;
                out_pc_s    = pc_r;
                out_insn_s  = {16'h0000, mem_rdata[31:16]};
                out_rvc_s   = 1'b1;
              end else begin
                mem_valid_s = 1'b1;
                mem_addr_s  = (pc_r + 32'd2) & 32'hFFFF_FFFC;
              end
            end
          end else begin
            state_s = S_FETCH;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            pc_s = pc_adv_s;
            if (hit_adv_s && is_rvc(buf_r)) begin
              // Next instruction is already buffered: no memory read.
              out_valid_s = 1'b1;
              out_pc_s    = pc_adv_s;
              out_insn_s  = {16'h0000, buf_r};
              out_rvc_s   = 1'b1;
            end else begin
              state_s     = S_FETCH;
              out_valid_s = 1'b0;
              mem_valid_s = 1'b1;
              mem_addr_s  = fetch_addr(pc_adv_s, buf_valid_r, buf_addr_r);
            end
          end else begin
            state_s = S_OUT;
          end
        end
        S_DROP: begin
          if (mem_ready) begin
            state_s     = S_FETCH;
            mem_valid_s = 1'b1;
            mem_addr_s  = pc_r & 32'hFFFF_FFFC;
          end else begin
            state_s = S_DROP;
          end
        end
        default: begin
          state_s     = S_FETCH;
          mem_valid_s = 1'b0;
          out_valid_s = 1'b0;
          buf_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output update; reset abandons any read in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_FETCH;
      pc_r        <= PROGADDR_RESET;
      buf_r       <= 16'h0000;
      buf_valid_r <= 1'b0;
      buf_addr_r  <= 32'h0000_0000;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      out_valid_r <= 1'b0;
      out_insn_r  <= 32'h0000_0000;
      out_pc_r    <= 32'h0000_0000;
      out_rvc_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      buf_r       <= buf_s;
      buf_valid_r <= buf_valid_s;
      buf_addr_r  <= buf_addr_s;
      mem_valid_r <= mem_valid_s;
      mem_addr_r  <= mem_addr_s;
      out_valid_r <= out_valid_s;
      out_insn_r  <= out_insn_s;
      out_pc_r    <= out_pc_s;
      out_rvc_r   <= out_rvc_s;
    end
  end

  assign mem_valid = mem_valid_r;
  assign mem_addr  = mem_addr_r;
  assign out_valid = out_valid_r;
  assign out_insn  = out_insn_r;
  assign out_pc    = out_pc_r;
  assign out_rvc   = out_rvc_r;

endmodule
